// File: rtl/ifetch_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ifetch_stage
// Purpose  : Instruction fetch: one outstanding imem read, {pc, instr} FIFO
//            toward decode, PC halt control and redirect squashing.
// Revision : 1.0  initial release
// ============================================================================
module ifetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0120,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic [31:0] pc_i,
  input  logic        redirect_i,
  output logic        stall_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o
);

  localparam int          PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GNT = 2'd1,
    WAIT_RSP = 2'd2,
    DROP     = 2'd3
  } state_t;

  state_t             state;
  logic               kill;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [31:0]        instr_mem [DEPTH];
  logic [31:0]        pc_mem    [DEPTH];

  logic               push;
  logic               pop;
  logic               has_room;
  logic               room_after;
  logic [CNT_W:0]     cnt_after;

  assign id_valid_o = (count != '0);
  assign pop        = id_valid_o & id_ready_i;
  assign push       = (state == WAIT_RSP) & imem_rvalid_i & ~redirect_i;
  assign has_room   = (count < CNT_W'(DEPTH));
  // Occupancy once the returning word lands, used to decide back-to-back issue.
  assign cnt_after  = {1'b0, count} + (CNT_W+1)'(1) - (CNT_W+1)'(pop);
  assign room_after = (cnt_after < (CNT_W+1)'(DEPTH));

  assign stall_o    = ~(imem_req_o & imem_gnt_i & ~kill & ~redirect_i);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= IDLE;
      kill        <= 1'b0;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (has_room && !redirect_i) begin
            imem_addr_o <= pc_i;
            imem_req_o  <= 1'b1;
            state       <= WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          // A posted request stays up until granted; redirect only marks it stale.
          if (imem_gnt_i) begin
            imem_req_o <= 1'b0;
            kill       <= 1'b0;
            state      <= (kill || redirect_i) ? DROP : WAIT_RSP;
          end else if (redirect_i) begin
            kill <= 1'b1;
          end
        end
        WAIT_RSP: begin
          if (imem_rvalid_i) begin
            if (!redirect_i && room_after) begin
              imem_addr_o <= pc_i;
              imem_req_o  <= 1'b1;
              state       <= WAIT_GNT;
            end else begin
              state <= IDLE;
            end
          end else if (redirect_i) begin
            state <= DROP;
          end
        end
        DROP: begin
          if (imem_rvalid_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata_i;
      pc_mem[wr_ptr]    <= imem_addr_o;
    end
  end

  assign id_instr_o = id_valid_o ? instr_mem[rd_ptr] : NOP_INSTR;
  assign id_pc_o    = id_valid_o ? pc_mem[rd_ptr]    : RESET_PC;

endmodule

`default_nettype wire

// File: doc/ifetch_stage.md
# ifetch_stage

Instruction-fetch stage between the program counter and decode. It samples the current PC, issues one instruction-memory read at a time over a req/gnt/rvalid handshake, and buffers returned {pc, instruction} pairs in a small FIFO toward decode. It drives the PC halt input so the PC advances exactly once per accepted fetch. It also discards in-flight fetches when a jump or branch redirects the PC.

## Interface
- RESET_PC, 32'h0000_0120: value of imem_addr_o and id_pc_o out of reset; matches the PC reset value.
- DEPTH, 2: FIFO entries, power of two, ≥2.
- clk_i  in  1  sole clock; all state updates on posedge.
- reset_ni  in  1  asynchronous, active-low reset.
- pc_i  in  32  current PC from the PC register.
- redirect_i  in  1  jump or branch taken this cycle (same signal OR that makes the PC load its target).
- stall_o  out  1  to the PC halt input; low only in a cycle where a non-stale fetch is granted.
- imem_req_o  out  1  read request; registered.
- imem_addr_o  out  32  read address; registered, stable while imem_req_o is high.
- imem_gnt_i  in  1  memory accepts request this cycle.
- imem_rvalid_i  in  1  read data valid.
- imem_rdata_i  in  32  read data.
- id_valid_o  out  1  FIFO non-empty.
- id_ready_i  in  1  decode accepts head entry.
- id_instr_o  out  32  head instruction; 32'h0000_0013 (NOP) when id_valid_o is low.
- id_pc_o  out  32  PC of head instruction.

## Operation
- At most one outstanding memory transaction. FSM states: IDLE, WAIT_GNT, WAIT_RSP, DROP.
- IDLE → WAIT_GNT when count < DEPTH and !redirect_i. Latch imem_addr_o = pc_i and set imem_req_o = 1. Otherwise stay in IDLE.
- WAIT_GNT: imem_req_o and imem_addr_o are held until imem_gnt_i. Exit is to WAIT_RSP, or to DROP if the kill flag is set or redirect_i is high in the grant cycle. Clear imem_req_o on the grant edge.
- Kill flag: set by redirect_i in WAIT_GNT; cleared on leaving WAIT_GNT. A requested address is never withdrawn before grant.
- stall_o = !(imem_req_o & imem_gnt_i & !kill & !redirect_i).
- WAIT_RSP, on imem_rvalid_i:
  - Without redirect_i: push {imem_addr_o, imem_rdata_i}.
  - If count + 1 − pop < DEPTH and !redirect_i: latch pc_i, go to WAIT_GNT (back-to-back fetch). Otherwise go to IDLE.
- WAIT_RSP with redirect_i and no rvalid → DROP. WAIT_RSP with redirect_i and rvalid in the same cycle: discard the data, go to IDLE.
- DROP: on imem_rvalid_i, discard the data and go to IDLE. redirect_i in DROP has no further effect.
- imem_rvalid_i in IDLE or WAIT_GNT is ignored (protocol violation; flagged by an assertion in the bench).
- FIFO: pop = id_valid_o & id_ready_i.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- redirect_i flushes the FIFO: count and pointers go to 0. Flush beats a same-cycle push or pop.
- count width is clog2(DEPTH)+1. A push at count == DEPTH cannot occur, because a slot is reserved at issue.

## Timing
- Reset (asynchronous assert, synchronous release):
  - FSM in IDLE, kill = 0, count = 0, pointers = 0.
  - imem_req_o = 0, imem_addr_o = RESET_PC, id_valid_o = 0, id_instr_o = NOP, id_pc_o = RESET_PC.
  - stall_o = 1.
- Zero-wait memory, empty FIFO:
  - Cycle 0: IDLE latches pc_i.
  - Cycle 1: req and gnt, stall_o = 0, PC advances at the cycle-1 edge.
  - Cycle 2: rvalid, push.
  - Cycle 3: id_valid_o = 1.
- Steady-state throughput with zero-wait memory and free space: one fetch per 2 cycles.
- Reset asserted mid-transaction abandons the transaction immediately. After reset release, memory must not deliver stale rvalid.

## Test plan
- Reset release with pc_i = 0x120, gnt and rvalid same-cycle-capable, rdata = 0x00500093 → imem_addr_o = 0x120 at cycle 1, stall_o low only in cycle 1, id_valid_o high in cycle 3 with id_instr_o = 0x00500093 and id_pc_o = 0x120.
- id_ready_i held low, zero-wait memory → exactly DEPTH fetches (0x120, 0x124); FSM parks in IDLE, stall_o stays 1. Raising id_ready_i pops 0x120 first, and fetch resumes at 0x128.
- Grant delayed 3 cycles → imem_req_o and imem_addr_o stay stable for all 4 cycles; stall_o is low only in the grant cycle.
- redirect_i pulsed in WAIT_GNT (target 0x200) → grant taken with stall_o = 1, response discarded via DROP, FIFO empty. The next request address is 0x200.
- redirect_i coincident with imem_rvalid_i while the FIFO holds 1 entry → data dropped, id_valid_o low next cycle, next fetch uses the new pc_i.
- reset_ni asserted asynchronously mid-WAIT_RSP (between clock edges) → imem_req_o, id_valid_o and count go to reset values before the next edge.
